// File: rtl/cryptoveril_pkg.sv
// Shared cipher definitions: field widths, decrypt FSM states, request payload
// and the key expansion used by both the encrypt and decrypt paths.
package cryptoveril_pkg;

    localparam int unsigned KEY_W  = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ROT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ROT  = 2'd2,
        XOR  = 2'd3
    } state_t;

    // Word and key captured together when a request is accepted
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEY_W-1:0]  key;
    } req_t;

    // K16 = {key[0], key, key, key}
    function automatic logic [DATA_W-1:0] expand_key(input logic [KEY_W-1:0] key);
        return {key[0], key, key, key};
    endfunction

endpackage

// File: rtl/cryptoveril_decrypt_if.sv
// Request/response bundle for the decryptor.
//   start       : request pulse, sampled only when idle
//   input_data  : ciphertext word
//   key_bits    : 5-bit key
//   output_data : recovered plaintext (registered)
//   busy        : word in flight
//   done        : one-cycle completion pulse
interface cryptoveril_decrypt_if;
    import cryptoveril_pkg::*;

    logic              start;
    logic [DATA_W-1:0] input_data;
    logic [KEY_W-1:0]  key_bits;
    logic [DATA_W-1:0] output_data;
    logic              busy;
    logic              done;

    modport master (
        output start, input_data, key_bits,
        input  output_data, busy, done
    );

    modport slave (
        input  start, input_data, key_bits,
        output output_data, busy, done
    );

endinterface

// File: rtl/cryptoveril_rotr1.sv
// Combinational rotate-right-by-one of a data word.
//   din    : word to rotate
//   dout_c : din rotated right by one bit
module cryptoveril_rotr1
    import cryptoveril_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_c
);

    assign dout_c = {din[0], din[DATA_W-1:1]};

endmodule

// File: rtl/cryptoveril_decrypt.sv
// Multi-cycle cryptoveril decryptor: P = rotr16(C - key, key[3:0]) ^ K16.
// One word per accepted start; subtract, one rotate per cycle, then XOR.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : request/response bundle (slave side)
module cryptoveril_decrypt
    import cryptoveril_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    cryptoveril_decrypt_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q,  work_d;
    logic [KEY_W-1:0]  key_q,   key_d;
    logic [ROT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [DATA_W-1:0] rot_c;
    req_t              req_c;

    assign req_c = '{data: bus.input_data, key: bus.key_bits};

    cryptoveril_rotr1 u_rotr1 (
        .din    (work_q),
        .dout_c (rot_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = req_c.data;
                    key_d   = req_c.key;
                    state_d = SUB;
                end
            end
            SUB: begin
                // Wraps mod 2^16; borrow discarded
                work_d  = work_q - DATA_W'(key_q);
                cnt_d   = key_q[ROT_W-1:0];
                state_d = (key_q[ROT_W-1:0] == ROT_W'(0)) ? XOR : ROT;
            end
            ROT: begin
                work_d = rot_c;
                cnt_d  = cnt_q - ROT_W'(1);
                if (cnt_q == ROT_W'(1)) begin
                    state_d = XOR;
                end
            end
            XOR: begin
                out_d   = work_q ^ expand_key(key_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy tracks the registered state so it drops on the done edge
        busy_d = (state_d != IDLE);
    end

    assign bus.output_data = out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_cryptoveril_decrypt.sv
// Self-checking bench for cryptoveril_decrypt: directed table, busy/back-to-back
// and reset corner cases, then random round trips through a reference encryptor.
module tb_cryptoveril_decrypt;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_bad = 0;

    cryptoveril_decrypt_if bus ();

    cryptoveril_decrypt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  key;
        logic [15:0] cipher;
        logic [15:0] plain;
    } vec_t;

    vec_t vecs[5];

    // Reference model: key expansion and forward transform from the cipher rules
    function automatic logic [15:0] ref_k16(input logic [4:0] k);
        return {k[0], k, k, k};
    endfunction

    function automatic logic [15:0] ref_encrypt(input logic [15:0] p, input logic [4:0] k);
        int unsigned x;
        int unsigned r;
        x = 32'(p ^ ref_k16(k));
        r = 32'(k[3:0]);
        x = ((x << r) | (x >> (16 - r))) & 32'h0000_FFFF;
        x = (x + 32'(k)) & 32'h0000_FFFF;
        return x[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered at a negedge; leaves at the negedge of the done cycle with start low.
    task automatic run_word(input logic [4:0] key, input logic [15:0] c,
                            input logic [15:0] exp, input bit poke);
        int r;
        int lat;
        int bcnt;
        bit got;
        r = int'(key[3:0]);
        bus.start      = 1'b1;
        bus.input_data = c;
        bus.key_bits   = key;
        @(posedge clk);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.input_data = 16'($urandom);
        bus.key_bits   = 5'($urandom);
        bcnt = bus.busy ? 1 : 0;
        got  = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = poke && (k == 1);
            if (poke && k == 1) begin
                bus.input_data = ~c;
                bus.key_bits   = ~key;
            end
            if (bus.done) begin
                got = 1'b1;
                lat = k;
                break;
            end
            if (bus.busy) bcnt++;
        end
        chk("done_timeout", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(2 + r));
        chk("output_data", 32'(bus.output_data), 32'(exp));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("busy_cycles", 32'(bcnt), 32'(2 + r));
    endtask

    // One idle cycle after completion: pulse gone, result held, nothing queued
    task automatic idle_check(input logic [15:0] exp);
        @(negedge clk);
        chk("done_single_cycle", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("output_hold", 32'(bus.output_data), 32'(exp));
    endtask

    initial begin
        int seen;
        logic [15:0] p;
        logic [4:0]  k;

        vecs[0] = '{5'h00, 16'hA5A5, 16'hA5A5};
        vecs[1] = '{5'h01, 16'h0001, 16'h8421};
        vecs[2] = '{5'h1F, 16'h0000, 16'h003C};
        vecs[3] = '{5'h10, 16'h0010, 16'h4210};
        vecs[4] = '{5'h07, ref_encrypt(16'h1234, 5'h07), 16'h1234};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.input_data = 16'h0;
        bus.key_bits   = 5'h0;
        repeat (3) @(negedge clk);
        chk("reset_output", 32'(bus.output_data), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors; vector 3 gets an ignored mid-flight start
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].key, vecs[i].cipher, vecs[i].plain, i == 3);
            idle_check(vecs[i].plain);
        end

        // Back-to-back: second start issued in the done cycle
        run_word(5'h10, 16'h0010, 16'h4210, 1'b0);
        run_word(5'h07, ref_encrypt(16'hBEEF, 5'h07), 16'hBEEF, 1'b0);
        idle_check(16'hBEEF);

        // Reset mid-operation at edge 5
        bus.start      = 1'b1;
        bus.input_data = 16'h0000;
        bus.key_bits   = 5'h1F;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_output", 32'(bus.output_data), 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        // Reset and start together: request dropped
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.input_data = 16'h1111;
        bus.key_bits   = 5'h03;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(bus.busy), 32'd0);
        chk("rst_start_done", 32'(bus.done), 32'd0);

        // Random round trips
        for (int i = 0; i < 1000; i++) begin
            p = 16'($urandom);
            k = 5'($urandom);
            run_word(k, ref_encrypt(p, k), p, ($urandom % 8) == 0);
            if ($urandom_range(1, 0) == 1) idle_check(p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cryptoveril_decrypt.md
# cryptoveril_decrypt

Single-clock, multi-cycle decryptor that inverts the cryptoveril encryption transform, turning a 16-bit ciphertext word and the 5-bit key back into plaintext. It is the receive-side counterpart of the three-stage encrypt pipeline. It accepts one word per `start` pulse, walks a small state machine (subtract, iterative rotate, XOR), and reports completion with a one-cycle `done` pulse.

## Interface
Parameters: none (widths are fixed by the cipher definition).

Ports:
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `input_data`  in  16  ciphertext word; captured on the accepted `start` edge.
- `key_bits`  in  5  key; captured on the accepted `start` edge.
- `output_data`  out  16  plaintext; registered, holds until the next completion.
- `busy`  out  1  high while a word is in flight.
- `done`  out  1  one-cycle pulse when `output_data` has just been updated.

## Operation
- Key expansion: K16 = {key[0], key, key, key} (1+5+5+5 bits). Rotation amount r = key[3:0].
- Encrypt transform being inverted: C = rotl16(P ^ K16, r) + {11'd0, key}, taken mod 2^16.
- Decrypt: P = rotr16(C − {11'd0, key}, r) ^ K16. The subtraction wraps mod 2^16, and the borrow is discarded.
- Internal registers: 16-bit work register, latched 5-bit key, 4-bit rotate counter, state.
- FSM states and transitions:
  - IDLE: on `start`, latch data and key, then go to SUB. Otherwise stay in IDLE.
  - SUB: work ← work − key; counter ← r. Go to ROT if r ≠ 0, else go to XOR.
  - ROT: work ← rotr1(work); counter ← counter − 1. Go to XOR when counter == 1, else stay in ROT.
  - XOR: `output_data` ← work ^ K16; `done` ← 1. Go to IDLE.
- `start` while `busy` is ignored. The in-flight word is unaffected and no queueing occurs.
- `input_data` and `key_bits` may change freely after capture.

## Timing
- Reset values: `output_data` = 16'h0000, `busy` = 0, `done` = 0, state = IDLE, counter = 0.
- Label the edge that accepts `start` as edge 0:
  - SUB executes at edge 1.
  - Rotations execute at edges 2 … 1+r.
  - XOR executes at edge 2+r.
- Latency: `done` is high, and `output_data` is valid, for the single cycle after edge 2+r. Range: 2 edges (r=0) to 17 edges (r=15).
- `busy` rises after edge 0 and falls at edge 2+r, at the same edge `done` rises.
- Back-to-back operation: `start` asserted during the `done` cycle is accepted, because the state is already IDLE. Throughput is one word per 3+r cycles.
- Reset mid-operation: the next edge returns everything to reset values. There is no partial `done`, and `output_data` is cleared.
- `rst` and `start` asserted together: reset wins and the request is dropped.

## Structure
- Shared package `cryptoveril_pkg` contains:
  - the state enum (IDLE/SUB/ROT/XOR);
  - `KEY_W` = 5 and `DATA_W` = 16;
  - an expand-key function returning K16, so the encrypt stages and any models use the identical expansion.
- One sub-module is natural: `cryptoveril_rotr1`, a combinational 16-bit rotate-right-by-one used by ROT. The main FSM stays in `cryptoveril_decrypt`.

## Test plan
- Identity key: key=5'h00, input_data=16'hA5A5, start at edge 0 → `output_data`=16'hA5A5 and `done` high after edge 2; `busy` high exactly 2 cycles.
- Single rotate: key=5'h01 (K16=16'h8421, r=1), input_data=16'h0001 → `output_data`=16'h8421 with `done` after edge 3.
- Subtract wrap plus max rotate: key=5'h1F (K16=16'hFFFF, r=15), input_data=16'h0000 → intermediate 16'hFFE1, after rotates 16'hFFC3, `output_data`=16'h003C with `done` after edge 17.
- Busy protection and back-to-back:
  - key=5'h10, input_data=16'h0010 → 16'h4210.
  - A second `start` with other data mid-operation is ignored.
  - A `start` in the `done` cycle is accepted, and its result appears 2+r edges later.
- Reset mid-operation: key=5'h1F, assert `rst` at edge 5 → `busy`=0, `done`=0, `output_data`=0 next cycle, and no `done` pulse ever appears for that word.
- Round trip: 1000 random (P, key) pairs encrypted by the reference model, then decrypted → `output_data` == P every time, with `done` latency == 2+key[3:0].
